// File: rtl/pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit
//
// Hazard and forwarding controller for the MIPS32 pipeline. It keeps a
// scoreboard of in-flight register writers, one entry per stage from EX
// onward, and produces three things:
//   - forward selects for the two EX operands, registered as the consumer
//     moves from ID into EX
//   - a load-use stall
//   - redirect flushes for taken branches and resolved jumps
//
// Parameters:
//   REG_AW    register address width
//   FWD_DEPTH number of stages after EX that can forward (1..6)
//   LOAD_LAT  a load is forwardable only from scoreboard index > LOAD_LAT-1
//             (that is, stage index > LOAD_LAT); range 0..FWD_DEPTH-1
//   FW        forward-select width (derived)
//
// Ports:
//   clk, reset        rising-edge clock; asynchronous active-high reset
//   hold              global freeze: nothing registered updates
//   id_*              decoded fields of the instruction sitting in ID
//   ex_redirect       branch taken or jump resolved in EX this cycle
//   stall             hold PC and IF/ID, load a bubble into ID/EX (comb)
//   flush_if_id       clear IF/ID (comb)
//   flush_id_ex       load a bubble into ID/EX (comb)
//   fwd_a, fwd_b      EX operand selects: 0 = register file,
//                     k = result held k stages after EX
//   stall_cnt,
//   flush_cnt         saturating event counters, present only when the
//                     macro HAZ_PERF_CNT_EN is defined
//
// Handshake: there is no valid/ready pair here. The pipeline obeys stall and
// flush in the same cycle they are asserted; during hold it ignores them.
// ---------------------------------------------------------------------------
module pipe_hazard_unit #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int FW        = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_reg_write,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  output logic              stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  // Scoreboard: index 0 is the instruction in EX, index j is j stages later.
  logic [FWD_DEPTH-1:0] s_valid;
  logic [FWD_DEPTH-1:0] s_load;
  logic [REG_AW-1:0]    s_dest [FWD_DEPTH];

  logic [FW-1:0] code_a;
  logic [FW-1:0] code_b;
  logic          load_hz_a;
  logic          load_hz_b;
  logic          bubble;
  logic          id_writes;

  // Youngest-match search. Scanning from the oldest entry down to index 0
  // lets the youngest matching writer overwrite any older one.
  always_comb begin
    code_a    = '0;
    code_b    = '0;
    load_hz_a = 1'b0;
    load_hz_b = 1'b0;
    for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
      if (id_use_rs && s_valid[j] && (s_dest[j] == id_rs) && (id_rs != '0)) begin
        code_a    = FW'(j + 1);
        load_hz_a = s_load[j] && (j < LOAD_LAT);
      end
      if (id_use_rt && s_valid[j] && (s_dest[j] == id_rt) && (id_rt != '0)) begin
        code_b    = FW'(j + 1);
        load_hz_b = s_load[j] && (j < LOAD_LAT);
      end
    end
  end

  // A redirect squashes the ID instruction anyway, so it overrides stall.
  assign stall       = id_valid && (load_hz_a || load_hz_b) && !ex_redirect;
  assign flush_if_id = ex_redirect && !hold;
  assign flush_id_ex = ex_redirect && !hold;

  assign bubble    = stall || flush_id_ex;
  assign id_writes = id_valid && id_reg_write && (id_dest != '0);

  // Writes to $0 never enter the scoreboard; the oldest entry simply falls
  // off on the next shift because the register file is write-first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_valid <= '0;
      s_load  <= '0;
      for (int j = 0; j < FWD_DEPTH; j++) s_dest[j] <= '0;
      fwd_a   <= '0;
      fwd_b   <= '0;
    end else if (!hold) begin
      for (int j = 1; j < FWD_DEPTH; j++) begin
        s_valid[j] <= s_valid[j-1];
        s_load[j]  <= s_load[j-1];
        s_dest[j]  <= s_dest[j-1];
      end
      s_valid[0] <= id_writes && !bubble;
      s_load[0]  <= id_is_load;
      s_dest[0]  <= id_dest;
      fwd_a      <= bubble ? '0 : code_a;
      fwd_b      <= bubble ? '0 : code_b;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!hold) begin
      if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (flush_id_ex && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_unit
//
// Directed bench for pipe_hazard_unit. A default instance (FWD_DEPTH=2,
// LOAD_LAT=1) runs a table of per-cycle vectors; a second instance
// (FWD_DEPTH=3, LOAD_LAT=2) shares the same inputs and is checked in the
// hand-written long-load/hold sequence. Inputs change 1ns after the rising
// edge, combinational outputs are sampled mid-cycle, and registered outputs
// are sampled 1ns after the edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       hold, id_valid, id_use_rs, id_use_rt, id_reg_write, id_is_load, ex_redirect;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       stall, flush_if_id, flush_id_ex;
  logic [1:0] fwd_a, fwd_b;
  logic       stall3, flush_if_id3, flush_id_ex3;
  logic [1:0] fwd_a3, fwd_b3;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt, stall_cnt3, flush_cnt3;
`endif

  pipe_hazard_unit dut (
    .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_reg_write(id_reg_write), .id_dest(id_dest), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .stall(stall), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  pipe_hazard_unit #(.REG_AW(5), .FWD_DEPTH(3), .LOAD_LAT(2)) dut3 (
    .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_reg_write(id_reg_write), .id_dest(id_dest), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .stall(stall3), .flush_if_id(flush_if_id3),
    .flush_id_ex(flush_id_ex3), .fwd_a(fwd_a3), .fwd_b(fwd_b3)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
`endif
  );

  // ---------------- vector record ----------------
  typedef struct {
    logic       hold;
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       wr;
    logic [4:0] dest;
    logic       ld;
    logic       redir;
    logic       exp_stall;
    logic       exp_flush;
    logic [1:0] exp_fa;
    logic [1:0] exp_fb;
  } vec_t;

  vec_t vecs[$];
  logic [3:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard compare ----------------
  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic vec_t mk(input logic h, input logic v, input int rs, input int rt,
                              input logic urs, input logic urt, input logic wr,
                              input int dest, input logic ld, input logic redir,
                              input logic es, input logic ef, input int fa, input int fb);
    vec_t r;
    r.hold = h; r.valid = v; r.rs = 5'(rs); r.rt = 5'(rt);
    r.use_rs = urs; r.use_rt = urt; r.wr = wr; r.dest = 5'(dest);
    r.ld = ld; r.redir = redir; r.exp_stall = es; r.exp_flush = ef;
    r.exp_fa = 2'(fa); r.exp_fb = 2'(fb);
    return r;
  endfunction

  task automatic drive(input vec_t v);
    hold = v.hold; id_valid = v.valid; id_rs = v.rs; id_rt = v.rt;
    id_use_rs = v.use_rs; id_use_rt = v.use_rt; id_reg_write = v.wr;
    id_dest = v.dest; id_is_load = v.ld; ex_redirect = v.redir;
  endtask

  task automatic set_instr(input logic v, input int rs, input int rt, input logic urs,
                           input logic urt, input logic wr, input int dest, input logic ld);
    drive(mk(1'b0, v, rs, rt, urs, urt, wr, dest, ld, 1'b0, 1'b0, 1'b0, 0, 0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_instr(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- test body ----------------
  initial begin
    // cols: hold valid rs rt urs urt wr dest ld redir | stall flush fa fb
    // forwarding from the instruction just ahead; hold freezes fwd
    vecs.push_back(mk(0,1, 1,2, 1,1, 1, 3,0,0, 0,0, 0,0)); // add $3=$1+$2
    vecs.push_back(mk(0,1, 3,5, 1,1, 1, 4,0,0, 0,0, 1,0)); // sub $4=$3-$5
    vecs.push_back(mk(1,1, 4,3, 1,1, 1, 6,0,0, 0,0, 1,0)); // frozen
    vecs.push_back(mk(0,1, 4,3, 1,1, 1, 6,0,0, 0,0, 1,2)); // $4 from MEM, $3 from WB
    vecs.push_back(mk(0,0, 0,0, 0,0, 0, 0,0,0, 0,0, 0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0, 0,0,0, 0,0, 0,0));
    // load-use: one stall, then forward from WB on both operands
    vecs.push_back(mk(0,1, 1,0, 1,0, 1, 3,1,0, 0,0, 0,0)); // lw $3
    vecs.push_back(mk(0,1, 3,3, 1,1, 1, 4,0,0, 1,0, 0,0)); // add $4=$3+$3 stalls
    vecs.push_back(mk(0,1, 3,3, 1,1, 1, 4,0,0, 0,0, 2,2));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0, 0,0,0, 0,0, 0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0, 0,0,0, 0,0, 0,0));
    // two writers of $7: youngest wins; $0 never forwards
    vecs.push_back(mk(0,1, 0,0, 0,0, 1, 7,0,0, 0,0, 0,0));
    vecs.push_back(mk(0,1, 0,0, 0,0, 1, 7,0,0, 0,0, 0,0));
    vecs.push_back(mk(0,1, 7,7, 1,1, 1, 8,0,0, 0,0, 1,1));
    vecs.push_back(mk(0,1, 0,0, 0,0, 1, 0,0,0, 0,0, 0,0)); // write $0
    vecs.push_back(mk(0,1, 0,0, 1,1, 0, 0,0,0, 0,0, 0,0)); // read $0
    // redirect while a load-use would stall
    vecs.push_back(mk(0,1, 0,0, 0,0, 1, 3,1,0, 0,0, 0,0)); // lw $3
    vecs.push_back(mk(0,1, 3,0, 1,0, 1, 4,0,1, 0,1, 0,0)); // consumer, redirect
    vecs.push_back(mk(0,0, 0,0, 0,0, 0, 0,0,0, 0,0, 0,0));
    vecs.push_back(mk(1,0, 0,0, 0,0, 0, 0,0,1, 0,0, 0,0)); // redirect under hold
    // load-use on the rt source only
    vecs.push_back(mk(0,1, 0,0, 0,0, 1, 5,1,0, 0,0, 0,0)); // lw $5
    vecs.push_back(mk(0,1, 0,5, 0,1, 1, 6,0,0, 1,0, 0,0));
    vecs.push_back(mk(0,1, 0,5, 0,1, 1, 6,0,0, 0,0, 0,2));

    // reset state
    do_reset();
    #3;
    check("rst_stall", stall, 0);
    check("rst_flush", flush_id_ex, 0);
    check("rst_fwd_a", fwd_a, 0);
    check("rst_fwd_b", fwd_b, 0);
    check("rst_stall3", stall3, 0);
    tick();

    // table-driven section on the default instance
    for (int i = 0; i < vecs.size(); i++) begin
      logic [3:0] e;
      drive(vecs[i]);
      #3;
      check($sformatf("v%0d_stall", i), stall, vecs[i].exp_stall);
      check($sformatf("v%0d_flush_if_id", i), flush_if_id, vecs[i].exp_flush);
      check($sformatf("v%0d_flush_id_ex", i), flush_id_ex, vecs[i].exp_flush);
      exp_q.push_back({vecs[i].exp_fa, vecs[i].exp_fb});
      tick();
      e = exp_q.pop_front();
      check($sformatf("v%0d_fwd_a", i), fwd_a, e[3:2]);
      check($sformatf("v%0d_fwd_b", i), fwd_b, e[1:0]);
    end

    // FWD_DEPTH=3, LOAD_LAT=2: two stall edges, hold for 4 in the middle
    do_reset();
    set_instr(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 9, 1'b1);   // lw $9
    tick();
    set_instr(1'b1, 9, 0, 1'b1, 1'b0, 1'b1, 10, 1'b0);  // consumer of $9
    #3 check("d3_stall_first", stall3, 1);
    tick();
    check("d3_fwd_a_bubble", fwd_a3, 0);
    hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #3;
      check($sformatf("d3_hold%0d_stall", k), stall3, 1);
      check($sformatf("d3_hold%0d_flush", k), flush_id_ex3, 0);
      tick();
      check($sformatf("d3_hold%0d_fwd_a", k), fwd_a3, 0);
    end
    hold = 1'b0;
    #3 check("d3_stall_second", stall3, 1);
    tick();
    #3 check("d3_stall_released", stall3, 0);
    tick();
    check("d3_fwd_a", fwd_a3, 3);
    check("d3_fwd_b", fwd_b3, 0);

    // reset asserted while a load-use stall is pending and fwd_a is live
    do_reset();
    set_instr(1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 3, 1'b0);   // add $3
    tick();
    set_instr(1'b1, 3, 0, 1'b1, 1'b0, 1'b1, 5, 1'b1);   // lw $5 reads $3
    tick();
    check("mr_fwd_a_before", fwd_a, 1);
    set_instr(1'b1, 5, 0, 1'b1, 1'b0, 1'b1, 6, 1'b0);   // consumer of $5
    #2 check("mr_stall_before", stall, 1);
    reset = 1'b1;
    #1;
    check("mr_stall_async", stall, 0);
    check("mr_fwd_a_async", fwd_a, 0);
    check("mr_fwd_b_async", fwd_b, 0);
    tick();
    reset = 1'b0;
    #3 check("mr_no_linger", stall, 0);
    tick();
    check("mr_fwd_a_after", fwd_a, 0);

`ifdef HAZ_PERF_CNT_EN
    // event counters: 5 load-use stalls, 3 flushes, one redirect under hold
    do_reset();
    check("cnt_rst_stall", stall_cnt, 0);
    check("cnt_rst_flush", flush_cnt, 0);
    for (int k = 0; k < 5; k++) begin
      set_instr(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b1);
      tick();
      set_instr(1'b1, 3, 0, 1'b1, 1'b0, 1'b1, 4, 1'b0);
      tick();
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      set_instr(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      ex_redirect = 1'b1;
      hold = (k == 3);
      tick();
    end
    ex_redirect = 1'b0;
    hold = 1'b0;
    check("cnt_stall", stall_cnt, 5);
    check("cnt_flush", flush_cnt, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
